// File: rtl/sipo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sipo_pkg : shared constants for the serial-in / parallel-out register
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
package sipo_pkg;

  localparam int   SIPO_WIDTH_DEF = 4;
  localparam logic SIPO_RST_VAL   = '0;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sipo_stage : one synchronous-reset D flop of the shift chain
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
module sipo_stage
  import sipo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SIPO_RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sipo_stage
`default_nettype wire

// File: rtl/sipo_4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sipo_4 : WIDTH-bit serial-in, parallel-out shift register (newest bit at 0)
// Rev 1.0: initial release
// ---------------------------------------------------------------------------
module sipo_4
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  output logic [WIDTH-1:0] p_out
);

  // chain[0] is the serial input; chain[i+1] is the output of stage i
  logic [WIDTH:0] chain;

  assign chain[0] = s_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    sipo_stage u_stage (
      .clk (clk),
      .rst (rst),
      .d   (chain[i]),
      .q   (chain[i+1])
    );
  end

  assign p_out = chain[WIDTH:1];

endmodule : sipo_4
`default_nettype wire

// File: tb/tb_sipo_4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sipo_4 : directed bench for sipo_4 at WIDTH=4 and WIDTH=8
// Rev 1.0   : initial release
// ---------------------------------------------------------------------------
module tb_sipo_4;
  import sipo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_in4 = 1'b0;
  logic       s_in8 = 1'b0;
  logic [3:0] p_out4;
  logic [7:0] p_out8;

  int n_checks = 0;
  int n_errors = 0;

  always #25 clk = ~clk;

  sipo_4 #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_in4),
    .p_out (p_out4)
  );

  sipo_4 #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_in8),
    .p_out (p_out8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, settle 1 ns.
  task automatic step(input logic r, input logic s4, input logic s8);
    @(negedge clk);
    rst   = r;
    s_in4 = s4;
    s_in8 = s8;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fill_in   = 4'b1100;
  logic [3:0] fill_exp [4] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100};
  logic [7:0] cont_in   = 8'b11001111;
  logic [3:0] cont_exp [8] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100,
                               4'b1001, 4'b0011, 4'b0111, 4'b1111};
  logic [3:0] walk_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic [7:0] word8     = 8'b10110011;

  initial begin
    // reset held two edges
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("reset4", {4'b0, p_out4}, {4'b0, {4{SIPO_RST_VAL}}});
    check("reset8", p_out8, {8{SIPO_RST_VAL}});

    // fill: 1,1,0,0 (MSB of fill_in first)
    for (int i = 0; i < 4; i++) begin
      step(1'b0, fill_in[3-i], 1'b0);
      check($sformatf("fill%0d", i), {4'b0, p_out4}, {4'b0, fill_exp[i]});
    end

    // continue stream 1,1,0,0,1,1,1,1
    for (int i = 0; i < 8; i++) begin
      step(1'b0, cont_in[7-i], 1'b0);
      check($sformatf("cont%0d", i), {4'b0, p_out4}, {4'b0, cont_exp[i]});
    end

    // reset beats s_in=1, then shifting resumes from zero
    step(1'b1, 1'b1, 1'b1);
    check("midrst", {4'b0, p_out4}, 8'h00);
    check("midrst8", p_out8, 8'h00);
    step(1'b0, 1'b1, 1'b0);
    check("resume", {4'b0, p_out4}, 8'h01);

    // walking one
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i == 0) ? 1'b1 : 1'b0, 1'b0);
      check($sformatf("walk%0d", i), {4'b0, p_out4}, {4'b0, walk_exp[i]});
    end

    // 8-bit instance: 10110011 MSB first
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, word8[7-i]);
      if (i == 3) check("w8_half", p_out8, 8'h0B);
    end
    check("w8_full", p_out8, 8'hB3);
    step(1'b0, 1'b0, 1'b1);
    check("w8_drop", p_out8, 8'h67);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sipo_4
`default_nettype wire

// File: doc/sipo_4.md
# sipo_4

Serial-in, parallel-out shift register, 4 bits wide by default. On every rising clock edge it captures one serial bit and shifts the previously captured bits one position toward the MSB. The full register is presented continuously on a parallel output. It is used as the deserialising front end for single-bit data streams feeding parallel datapaths.

## Interface
- `WIDTH`, default 4: register length in bits. Legal range is 2 or more.
- `clk` input, 1 bit: sole clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset. Synchronous, active-high. Sampled on the rising edge of `clk`.
- `s_in` input, 1 bit: serial data bit, sampled on every rising edge of `clk` when `rst` is 0.
- `p_out` output, `WIDTH` bits: parallel register contents, driven directly from flops.

One clock; reset is synchronous and active-high.

## Operation
- The state is a `WIDTH`-bit register `q`, and `p_out` equals `q` at all times.
- On a rising edge with `rst` = 1: `q` becomes all zeros. `s_in` is ignored on that edge.
- On a rising edge with `rst` = 0: `q` becomes `{q[WIDTH-2:0], s_in}`.
  - The new bit enters at bit 0.
  - The old bit `WIDTH-1` is discarded.
- There is no enable. A shift occurs on every non-reset edge, so a bit held on `s_in` for N cycles enters N times.
- There is no valid/full indication. After `WIDTH` non-reset edges, `p_out` holds the last `WIDTH` samples:
  - bit 0 holds the newest sample;
  - bit `WIDTH-1` holds the oldest sample.
- Reset mid-stream: the shift in progress is abandoned, `q` becomes 0 on that edge, and shifting resumes from zeros on the next non-reset edge.
- `rst` takes priority over `s_in` when both are active on the same edge.
- Unknown (X) on `s_in` propagates into bit 0 only. Reset clears it.

## Timing
- Latency: a bit sampled at edge k appears on `p_out[0]` immediately after edge k. It reaches `p_out[i]` after edge k+i.
- Reset: `p_out` is 0 from the first rising edge at which `rst` = 1. Before the first edge, `p_out` is undefined, and no power-on value is required.
- Reset release: the first edge with `rst` = 0 performs a shift.
- Outputs change only on rising edges. There are no combinational paths from inputs to `p_out`.

## Structure
- Shared package `sipo_pkg` holds:
  - the default width constant `SIPO_WIDTH_DEF = 4`;
  - the reset value constant `SIPO_RST_VAL = '0`, used for both reset and the bench check.
- One sub-module is natural: `sipo_stage`, a single synchronous-reset D flop (`clk`, `rst`, `d`, `q`).
  - The top generates `WIDTH` instances of it.
  - Stage 0 has `d` = `s_in`; stage i has `d` = stage i-1 `q`.

## Test plan
Assumed setup: 50 ns clock period, `s_in` changes every 100 ns (two edges per bit).
- Reset: hold `rst` = 1 for 2 edges with `s_in` = 0 -> `p_out` = 0000.
- Fill: after reset, `s_in` = 1 for 2 edges, then 0 for 2 edges -> `p_out` sequence 0001, 0011, 0110, 1100.
- Continue the same stream: 1, 1, 0, 0, 1, 1, 1, 1 -> `p_out` sequence 1001, 0011, 0110, 1100, 1001, 0011, 0111, 1111.
- Reset mid-stream: with `p_out` = 1111, assert `rst` for one edge with `s_in` = 1 -> `p_out` = 0000. On the next edge with `s_in` = 1 -> 0001.
- Walking one: after reset, `s_in` = 1 for one edge then 0 -> `p_out` sequence 0001, 0010, 0100, 1000, 0000.
- Parameter check: `WIDTH` = 8, shift in 8'b10110011 MSB first -> `p_out` = 0xB3 after 8 edges.
